// File: rtl/xbus_pkg.sv
// Shared types and constants for the 8088 I/O bus responder.
package xbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    WAIT   = 2'd2,
    ACTIVE = 2'd3
  } xbus_state_t;

  localparam int NUM_IRQ = 4;
  localparam int NUM_GP  = 6;

  localparam logic [2:0] PORT_MASK = 3'd6;
  localparam logic [2:0] PORT_PEND = 3'd7;

  // Index of the lowest set bit; 7 when nothing is set, which conveniently
  // makes VECTOR_BASE + index the spurious vector.
  function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbus_if.sv
// CPU-side I/O bus signals seen by the responder.
interface xbus_if;
  logic        pclk;
  logic        ale;
  logic        iom;
  logic        rd_n;
  logic        wr_n;
  logic        inta_n;
  logic        hlda;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_en;
  logic        ready;
  logic        intr;

  modport master (
    output pclk, ale, iom, rd_n, wr_n, inta_n, hlda, addr, din,
    input  dout, dout_en, ready, intr
  );

  modport slave (
    input  pclk, ale, iom, rd_n, wr_n, inta_n, hlda, addr, din,
    output dout, dout_en, ready, intr
  );
endinterface

// File: rtl/xbus_irq_ctrl.sv
// Four-source interrupt controller: edge-captured pending bits, mask,
// lowest-index priority and the two-pulse INTA vector handshake.
module xbus_irq_ctrl
  import xbus_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE = 8'h20
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               inta_n,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               pend_w1c,
  input  logic [NUM_IRQ-1:0] w1c_data,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pend,
  output logic               intr,
  output logic               vec_en,
  output logic [7:0]         vector
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pend_next;
  logic               inta_q;
  logic               inta_fall;
  logic               inta_rise;
  logic               inta_cnt;
  logic [2:0]         vec_idx;

  assign irq_rise  = irq_src & ~irq_q;
  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;
  assign vector    = VECTOR_BASE + {5'b0, vec_idx};

  // Pending update: clears first, then new edges so a same-cycle edge survives.
  always_comb begin
    clr = '0;
    if (pend_w1c) clr = clr | w1c_data;
    if (inta_rise && vec_en && (vec_idx < 3'(NUM_IRQ))) clr[vec_idx[1:0]] = 1'b1;
    pend_next = (pend & ~clr) | irq_rise;
  end

  // Edge history, pending/mask registers and the INTA pulse counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      irq_q    <= '0;
      inta_q   <= 1'b1;
      pend     <= '0;
      mask     <= '0;
      intr     <= 1'b0;
      inta_cnt <= 1'b0;
      vec_en   <= 1'b0;
      vec_idx  <= 3'd0;
    end else begin
      irq_q  <= irq_src;
      inta_q <= inta_n;
      pend   <= pend_next;
      intr   <= |(pend & mask);
      if (mask_we) mask <= mask_wdata;
      if (inta_fall) begin
        if (inta_cnt) begin
          vec_en  <= 1'b1;
          vec_idx <= lowest_set(pend & mask);
        end else begin
          inta_cnt <= 1'b1;
        end
      end else if (inta_rise && vec_en) begin
        vec_en   <= 1'b0;
        inta_cnt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/m_xbus_io_responder.sv
// I/O window responder for the 8088 bus: address decode, READY wait states,
// eight-port register file and the interrupt controller's vector output.
//
//   state  | meaning
//   IDLE   | no cycle for us; waiting for an ALE fall that hits the window
//   DECODE | address latched, waiting for rd_n or wr_n to fall
//   WAIT   | READY held low, counting pclk rising edges
//   ACTIVE | READY high; read data driven or write data being sampled
module m_xbus_io_responder
  import xbus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h00C0,
  parameter int          WAIT_STATES = 2,
  parameter logic [7:0]  VECTOR_BASE = 8'h20
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  xbus_if.slave              bus,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [47:0]        regs_out
);

  xbus_state_t state, state_next;

  logic               ale_q, rd_n_q, wr_n_q, pclk_q;
  logic               ale_fall, rd_fall, wr_fall, wr_rise, pclk_rise;
  logic               hit;
  logic               latch, load_wait, dec_wait, commit;
  logic               is_rd, rd_next;
  logic               io_en;
  logic [2:0]         idx;
  logic [7:0]         wait_cnt;
  logic [7:0]         wdata;
  logic [7:0]         rd_data;
  logic [7:0]         gp [NUM_GP];
  logic [NUM_IRQ-1:0] mask, pend;
  logic               vec_en;
  logic [7:0]         vector;

  assign ale_fall  = ale_q & ~bus.ale;
  assign rd_fall   = rd_n_q & ~bus.rd_n;
  assign wr_fall   = wr_n_q & ~bus.wr_n;
  assign wr_rise   = ~wr_n_q & bus.wr_n;
  assign pclk_rise = ~pclk_q & bus.pclk;
  assign hit       = bus.iom & (bus.addr[15:3] == BASE_ADDR[15:3]) & ~bus.hlda;

  // Registered copies of the CPU strobes for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ale_q  <= 1'b0;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      pclk_q <= 1'b0;
    end else begin
      ale_q  <= bus.ale;
      rd_n_q <= bus.rd_n;
      wr_n_q <= bus.wr_n;
      pclk_q <= bus.pclk;
    end
  end

  // Next-state decode; hlda overrides everything and aborts the cycle.
  always_comb begin
    state_next = state;
    latch      = 1'b0;
    load_wait  = 1'b0;
    dec_wait   = 1'b0;
    commit     = 1'b0;
    if (bus.hlda) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ale_fall && hit) begin
            state_next = DECODE;
            latch      = 1'b1;
          end
        end
        DECODE: begin
          if (ale_fall) begin
            latch      = hit;
            state_next = hit ? DECODE : IDLE;
          end else if (rd_fall || wr_fall) begin
            load_wait  = 1'b1;
            state_next = (WAIT_STATES == 0) ? ACTIVE : WAIT;
          end
        end
        WAIT: begin
          if (pclk_rise) begin
            if (wait_cnt <= 8'd1) state_next = ACTIVE;
            else                  dec_wait   = 1'b1;
          end
        end
        ACTIVE: begin
          if (bus.rd_n && bus.wr_n) begin
            state_next = IDLE;
            commit     = wr_rise & ~is_rd;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    // A read strobe seen at any point in the cycle turns it into a read.
    rd_next = load_wait ? ~bus.rd_n : (is_rd | ~bus.rd_n);
  end

  // State register, address latch, wait counter and write-data capture.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      wait_cnt <= 8'd0;
      is_rd    <= 1'b0;
      io_en    <= 1'b0;
      wdata    <= 8'h00;
    end else begin
      state <= state_next;
      is_rd <= rd_next;
      io_en <= (state_next == ACTIVE) & rd_next;
      if (latch)          idx      <= bus.addr[2:0];
      if (load_wait)      wait_cnt <= 8'(WAIT_STATES);
      else if (dec_wait)  wait_cnt <= wait_cnt - 8'd1;
      if (!bus.wr_n)      wdata    <= bus.din;
    end
  end

  // General-purpose port file, written when a write cycle completes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GP; i++) gp[i] <= 8'h00;
    end else if (commit && (idx < 3'(NUM_GP))) begin
      gp[idx] <= wdata;
    end
  end

  xbus_irq_ctrl #(
    .VECTOR_BASE (VECTOR_BASE)
  ) u_irq (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .irq_src    (irq_src),
    .inta_n     (bus.inta_n),
    .mask_we    (commit && (idx == PORT_MASK)),
    .mask_wdata (wdata[NUM_IRQ-1:0]),
    .pend_w1c   (commit && (idx == PORT_PEND)),
    .w1c_data   (wdata[NUM_IRQ-1:0]),
    .mask       (mask),
    .pend       (pend),
    .intr       (bus.intr),
    .vec_en     (vec_en),
    .vector     (vector)
  );

  // Read mux over the port map and flattening of ports 0..5.
  always_comb begin
    rd_data = 8'h00;
    if (idx < 3'(NUM_GP))       rd_data = gp[idx];
    else if (idx == PORT_MASK)  rd_data = {{(8-NUM_IRQ){1'b0}}, mask};
    else                        rd_data = {{(8-NUM_IRQ){1'b0}}, pend};
    regs_out = '0;
    for (int i = 0; i < NUM_GP; i++) regs_out[i*8 +: 8] = gp[i];
  end

  assign bus.dout    = io_en ? rd_data : (vec_en ? vector : 8'h00);
  assign bus.dout_en = io_en | vec_en;
  assign bus.ready   = (state != WAIT);

endmodule

// File: tb/tb_m_xbus_io_responder.sv
module tb_m_xbus_io_responder;
  localparam logic [7:0] VB = 8'h20;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        pclk = 1'b0, ale = 1'b0, iom = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic        inta_n = 1'b1, hlda = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  din = 8'h0;
  logic [3:0]  irq_src = 4'h0;
  logic [47:0] regs1, regs0;

  xbus_if bus1();
  xbus_if bus0();

  assign bus1.pclk = pclk;   assign bus0.pclk = pclk;
  assign bus1.ale = ale;     assign bus0.ale = ale;
  assign bus1.iom = iom;     assign bus0.iom = iom;
  assign bus1.rd_n = rd_n;   assign bus0.rd_n = rd_n;
  assign bus1.wr_n = wr_n;   assign bus0.wr_n = wr_n;
  assign bus1.inta_n = inta_n; assign bus0.inta_n = inta_n;
  assign bus1.hlda = hlda;   assign bus0.hlda = hlda;
  assign bus1.addr = addr;   assign bus0.addr = addr;
  assign bus1.din = din;     assign bus0.din = din;

  m_xbus_io_responder #(.BASE_ADDR(16'h00C0), .WAIT_STATES(2), .VECTOR_BASE(VB)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus1), .irq_src(irq_src), .regs_out(regs1));
  m_xbus_io_responder #(.BASE_ADDR(16'h00C0), .WAIT_STATES(0), .VECTOR_BASE(VB)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus0), .irq_src(irq_src), .regs_out(regs0));

  always #5 clk_sys = ~clk_sys;
  initial begin
    #2;
    forever #30 pclk = ~pclk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model of the programmer-visible state.
  logic [7:0] m_port [6];
  logic [3:0] m_mask, m_pend;

  function automatic logic [7:0] m_read(input logic [2:0] i);
    if (i < 3'd6) return m_port[i];
    if (i == 3'd6) return {4'h0, m_mask};
    return {4'h0, m_pend};
  endfunction

  function automatic logic [47:0] m_regs();
    return {m_port[5], m_port[4], m_port[3], m_port[2], m_port[1], m_port[0]};
  endfunction

  task automatic m_write(input logic [2:0] i, input logic [7:0] d);
    if (i < 3'd6) m_port[i] = d;
    else if (i == 3'd6) m_mask = d[3:0];
    else m_pend = m_pend & ~d[3:0];
  endtask

  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_port[i] = 8'h00;
    m_mask = 4'h0;
    m_pend = 4'h0;
  endtask

  // Highest-priority (lowest index) enabled pending source, 7 if none.
  function automatic int m_winner();
    for (int i = 0; i < 4; i++) if (m_pend[i] && m_mask[i]) return i;
    return 7;
  endfunction

  // Results of the last bus cycle / INTA pair.
  logic [7:0] r_dout1, r_dout0, r_vec;
  bit         r_en1, r_en0, r_anyen1, r_anyen0, r_anylow1, r_p1en, r_p2en, r_afteren;
  int         r_waits1, r_low0;

  task automatic bus_cycle(input bit io, input logic [15:0] a, input bit is_wr,
                           input logic [7:0] wd, input bit irq3_rel);
    bit p_prev, rdy_prev;
    @(negedge clk_sys);
    addr = a; iom = io; ale = 1'b1;
    repeat (2) @(negedge clk_sys);
    ale = 1'b0;
    repeat (2) @(negedge clk_sys);
    p_prev = pclk; rdy_prev = bus1.ready;
    r_waits1 = 0; r_low0 = 0; r_anyen1 = 0; r_anyen0 = 0; r_anylow1 = 0;
    if (is_wr) begin
      wr_n = 1'b0;
      din = 8'($urandom);
    end else begin
      rd_n = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (is_wr && i == 14) din = wd;
      if (pclk && !p_prev && !rdy_prev) r_waits1++;
      if (!bus1.ready) r_anylow1 = 1;
      if (!bus0.ready) r_low0++;
      if (bus1.dout_en) r_anyen1 = 1;
      if (bus0.dout_en) r_anyen0 = 1;
      p_prev = pclk; rdy_prev = bus1.ready;
    end
    r_dout1 = bus1.dout; r_en1 = bus1.dout_en;
    r_dout0 = bus0.dout; r_en0 = bus0.dout_en;
    checks++;
    if (bus1.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout addr=%h ready=%b exp=1", a, bus1.ready);
    end
    wr_n = 1'b1; rd_n = 1'b1;
    if (irq3_rel) irq_src[3] = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({bus1.dout_en, bus0.dout_en} !== 2'b00) begin
      errors++;
      $display("FAIL dout_en_release addr=%h got=%b%b exp=00", a, bus1.dout_en, bus0.dout_en);
    end
    iom = 1'b0; addr = 16'h0;
  endtask

  task automatic pulse_irq(input logic [3:0] m);
    @(negedge clk_sys);
    irq_src = irq_src | m;
    repeat (2) @(negedge clk_sys);
    irq_src = irq_src & ~m;
    repeat (3) @(negedge clk_sys);
    m_pend = m_pend | m;
  endtask

  task automatic inta_pair();
    @(negedge clk_sys); inta_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    r_p1en = bus1.dout_en;
    inta_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    inta_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    r_p2en = bus1.dout_en; r_vec = bus1.dout;
    inta_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    r_afteren = bus1.dout_en;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    m_reset();
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({bus1.dout, bus1.dout_en, bus1.ready, bus1.intr} !== {8'h00, 3'b010}) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%b%b%b exp=00/010", bus1.dout, bus1.dout_en, bus1.ready, bus1.intr);
    end
    checks++;
    if ({bus0.dout_en, bus0.ready, bus0.intr} !== 3'b010) begin
      errors++;
      $display("FAIL reset_outputs_ws0 got=%b%b%b exp=010", bus0.dout_en, bus0.ready, bus0.intr);
    end
    checks++;
    if ({regs1, regs0} !== 96'h0) begin
      errors++;
      $display("FAIL reset_regs got=%h %h exp=0", regs1, regs0);
    end
  endtask

  task automatic test_out_in();
    bus_cycle(1'b1, 16'h00C3, 1'b1, 8'h5A, 1'b0);
    m_write(3'd3, 8'h5A);
    checks++;
    if (r_waits1 !== 2) begin
      errors++;
      $display("FAIL out_wait_pclks got=%0d exp=2", r_waits1);
    end
    checks++;
    if ({regs1[31:24], regs0[31:24]} !== {m_port[3], m_port[3]}) begin
      errors++;
      $display("FAIL out_port3 got=%h %h exp=%h", regs1[31:24], regs0[31:24], m_port[3]);
    end
    bus_cycle(1'b1, 16'h00C3, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({r_en1, r_dout1, r_en0, r_dout0} !== {1'b1, m_port[3], 1'b1, m_port[3]}) begin
      errors++;
      $display("FAIL in_port3 got=%b/%h %b/%h exp=1/%h", r_en1, r_dout1, r_en0, r_dout0, m_port[3]);
    end
    checks++;
    if (r_waits1 !== 2 || r_low0 !== 0) begin
      errors++;
      $display("FAIL in_wait_pclks got=%0d ws0_low=%0d exp=2 0", r_waits1, r_low0);
    end
  endtask

  task automatic test_random_rw();
    for (int n = 0; n < 16; n++) begin
      bit io, wr, win, hit;
      logic [15:0] a;
      logic [7:0] d;
      win = ($urandom_range(0, 3) != 0);
      a = 16'($urandom);
      if (win) begin
        a = {13'h0018, a[2:0]};
        io = 1'b1;
      end else begin
        io = 1'($urandom);
        if (a[15:3] == 13'h0018) a[15] = 1'b1;
      end
      hit = io && (a[15:3] == 13'h0018);
      wr = 1'($urandom);
      d = 8'($urandom);
      bus_cycle(io, a, wr, d, 1'b0);
      if (hit) begin
        checks++;
        if (r_waits1 !== 2 || r_low0 !== 0) begin
          errors++;
          $display("FAIL rand_waits addr=%h got=%0d ws0_low=%0d exp=2 0", a, r_waits1, r_low0);
        end
        if (wr) begin
          m_write(a[2:0], d);
        end else begin
          checks++;
          if ({r_en1, r_dout1, r_en0, r_dout0} !== {1'b1, m_read(a[2:0]), 1'b1, m_read(a[2:0])}) begin
            errors++;
            $display("FAIL rand_read addr=%h got=%b/%h %b/%h exp=1/%h", a, r_en1, r_dout1, r_en0, r_dout0, m_read(a[2:0]));
          end
        end
      end else begin
        checks++;
        if ({r_anyen1, r_anyen0, r_anylow1} !== 3'b000 || r_low0 !== 0) begin
          errors++;
          $display("FAIL rand_miss addr=%h io=%b got=%b%b%b/%0d exp=000/0", a, io, r_anyen1, r_anyen0, r_anylow1, r_low0);
        end
      end
    end
    checks++;
    if (regs1 !== m_regs() || regs0 !== m_regs()) begin
      errors++;
      $display("FAIL rand_regs got=%h %h exp=%h", regs1, regs0, m_regs());
    end
  endtask

  task automatic test_miss();
    bus_cycle(1'b1, 16'h0080, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({r_anyen1, r_anyen0, r_anylow1} !== 3'b000 || r_low0 !== 0) begin
      errors++;
      $display("FAIL miss_io80 got=%b%b%b/%0d exp=000/0", r_anyen1, r_anyen0, r_anylow1, r_low0);
    end
    bus_cycle(1'b0, 16'h00C0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({r_anyen1, r_anyen0, r_anylow1} !== 3'b000 || r_low0 !== 0) begin
      errors++;
      $display("FAIL miss_mem got=%b%b%b/%0d exp=000/0", r_anyen1, r_anyen0, r_anylow1, r_low0);
    end
  endtask

  task automatic test_irq_vectors();
    logic [7:0] expv;
    bus_cycle(1'b1, 16'h00C6, 1'b1, 8'h06, 1'b0);
    m_write(3'd6, 8'h06);
    pulse_irq(4'h4);
    pulse_irq(4'h2);
    checks++;
    if ({bus1.intr, bus0.intr} !== 2'b11) begin
      errors++;
      $display("FAIL irq_intr_set got=%b%b exp=11", bus1.intr, bus0.intr);
    end
    for (int k = 0; k < 3; k++) begin
      expv = VB + 8'(m_winner());
      inta_pair();
      if (m_winner() != 7) m_pend[m_winner()] = 1'b0;
      checks++;
      if ({r_p1en, r_p2en, r_vec, r_afteren} !== {2'b01, expv, 1'b0}) begin
        errors++;
        $display("FAIL inta_vector k=%0d got=%b%b/%h/%b exp=01/%h/0", k, r_p1en, r_p2en, r_vec, r_afteren, expv);
      end
      bus_cycle(1'b1, 16'h00C7, 1'b0, 8'h00, 1'b0);
      checks++;
      if (r_dout1 !== {4'h0, m_pend} || r_dout0 !== {4'h0, m_pend}) begin
        errors++;
        $display("FAIL inta_pend k=%0d got=%h %h exp=%h", k, r_dout1, r_dout0, {4'h0, m_pend});
      end
    end
    checks++;
    if (bus1.intr !== 1'b0) begin
      errors++;
      $display("FAIL irq_intr_clear got=%b exp=0", bus1.intr);
    end
  endtask

  task automatic test_irq_random();
    logic [7:0] expv, mk;
    logic [3:0] src;
    for (int n = 0; n < 8; n++) begin
      mk = 8'($urandom);
      bus_cycle(1'b1, 16'h00C6, 1'b1, mk, 1'b0);
      m_write(3'd6, mk);
      src = 4'($urandom);
      pulse_irq(src);
      checks++;
      if (bus1.intr !== |(m_pend & m_mask)) begin
        errors++;
        $display("FAIL rirq_intr n=%0d got=%b exp=%b", n, bus1.intr, |(m_pend & m_mask));
      end
      expv = VB + 8'(m_winner());
      inta_pair();
      if (m_winner() != 7) m_pend[m_winner()] = 1'b0;
      checks++;
      if ({r_p1en, r_p2en, r_vec} !== {2'b01, expv}) begin
        errors++;
        $display("FAIL rirq_vector n=%0d got=%b%b/%h exp=01/%h", n, r_p1en, r_p2en, r_vec, expv);
      end
      bus_cycle(1'b1, 16'h00C7, 1'b0, 8'h00, 1'b0);
      checks++;
      if (r_dout1 !== {4'h0, m_pend}) begin
        errors++;
        $display("FAIL rirq_pend n=%0d got=%h exp=%h", n, r_dout1, {4'h0, m_pend});
      end
    end
  endtask

  task automatic test_set_wins();
    pulse_irq(4'h8);
    bus_cycle(1'b1, 16'h00C7, 1'b1, 8'h08, 1'b1);
    irq_src[3] = 1'b0;
    bus_cycle(1'b1, 16'h00C7, 1'b0, 8'h00, 1'b0);
    checks++;
    if (r_dout1[3] !== 1'b1 || r_dout1 !== {4'h0, m_pend}) begin
      errors++;
      $display("FAIL set_wins_w1c got=%h exp=%h", r_dout1, {4'h0, m_pend});
    end
    bus_cycle(1'b1, 16'h00C7, 1'b1, 8'h08, 1'b0);
    m_write(3'd7, 8'h08);
    bus_cycle(1'b1, 16'h00C7, 1'b0, 8'h00, 1'b0);
    checks++;
    if (r_dout1 !== {4'h0, m_pend} || r_dout1[3] !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear got=%h exp=%h", r_dout1, {4'h0, m_pend});
    end
  endtask

  task automatic test_hlda();
    logic [7:0] wd;
    wd = ~m_port[1];
    @(negedge clk_sys);
    addr = 16'h00C1; iom = 1'b1; ale = 1'b1;
    repeat (2) @(negedge clk_sys);
    ale = 1'b0;
    repeat (2) @(negedge clk_sys);
    wr_n = 1'b0; din = wd;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (bus1.ready !== 1'b0) begin
      errors++;
      $display("FAIL hlda_pre_wait ready=%b exp=0", bus1.ready);
    end
    hlda = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({bus1.ready, bus1.dout_en, bus0.ready, bus0.dout_en} !== 4'b1010) begin
      errors++;
      $display("FAIL hlda_abort got=%b%b%b%b exp=1010", bus1.ready, bus1.dout_en, bus0.ready, bus0.dout_en);
    end
    wr_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    hlda = 1'b0; iom = 1'b0; addr = 16'h0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (regs1 !== m_regs() || regs0 !== m_regs()) begin
      errors++;
      $display("FAIL hlda_no_commit got=%h %h exp=%h", regs1, regs0, m_regs());
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk_sys);
    addr = 16'h00C3; iom = 1'b1; ale = 1'b1;
    repeat (2) @(negedge clk_sys);
    ale = 1'b0;
    repeat (2) @(negedge clk_sys);
    rd_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({bus1.ready, bus0.dout_en, bus0.dout} !== {2'b01, m_port[3]}) begin
      errors++;
      $display("FAIL midread_pre got=%b%b/%h exp=01/%h", bus1.ready, bus0.dout_en, bus0.dout, m_port[3]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus1.ready, bus1.dout_en, bus0.ready, bus0.dout_en} !== 4'b1010) begin
      errors++;
      $display("FAIL midread_async_reset got=%b%b%b%b exp=1010", bus1.ready, bus1.dout_en, bus0.ready, bus0.dout_en);
    end
    checks++;
    if ({regs1, regs0} !== 96'h0) begin
      errors++;
      $display("FAIL midread_regs got=%h %h exp=0", regs1, regs0);
    end
    @(negedge clk_sys);
    rd_n = 1'b1; iom = 1'b0; addr = 16'h0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    m_reset();
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    test_reset();
    test_out_in();
    test_random_rw();
    test_miss();
    test_irq_vectors();
    test_irq_random();
    test_set_wins();
    test_hlda();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
